read_ecc_check: RTL

Per-sector Hamming ECC checker and single-bit corrector for the NAND read path. It accumulates line/column parity over each 256-byte data sector streamed from flash, compares it against the 3 stored ECC bytes that follow, and classifies the sector. On request, it repairs a single-bit error in place in the page buffer. It feeds `read_data_ECCstate` and `date_change_complete` to the read-flow controller.

---
 rtl/read_ecc_check.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/read_ecc_check.sv
// Per-sector Hamming ECC check (256 data + 3 ECC bytes) with in-place single-bit repair.
// Latency: result 2 cycles after the 259th byte; correction writes back 3 cycles after correct_start.
// Backpressure: none; din_valid gaps are tolerated and sector_start pre-empts any activity.
module read_ecc_check (
  input  logic        clk,
  input  logic        rst,
  input  logic        sector_start,
  input  logic [2:0]  sector_idx,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        correct_start,
  input  logic [7:0]  buf_rdata,
  output logic [1:0]  read_data_ECCstate,
  output logic        date_change_complete,
  output logic [10:0] err_addr,
  output logic [2:0]  err_bit,
  output logic [10:0] buf_addr,
  output logic        buf_rd,
  output logic        buf_we,
  output logic [7:0]  buf_wdata
);

  typedef enum logic [2:0] {IDLE, ACCUM, EVAL, RESULT, CORR_RD, CORR_WAIT, CORR_WR} state_t;

  state_t      state;
  logic [8:0]  cnt, cnt_b;
  logic [15:0] lp, lp_b, lp_n;
  logic [5:0]  cp, cp_b, cp_n;
  logic        all_ff, ff_b, ff_n;
  logic [7:0]  s0, s1;
  logic [5:0]  s2;
  logic [2:0]  idx;
  logic [21:0] syn_q;
  logic [10:0] pair_diff;
  logic [7:0]  syn_addr;
  logic [1:0]  res;
  logic        accept, par;

  // A byte coincident with sector_start counts as byte 0 of a freshly cleared accumulator.
  always_comb begin
    cnt_b  = sector_start ? 9'd0  : cnt;
    lp_b   = sector_start ? 16'd0 : lp;
    cp_b   = sector_start ? 6'd0  : cp;
    ff_b   = sector_start ? 1'b1  : all_ff;
    accept = din_valid && (sector_start || state == ACCUM);
    par    = ^din;
    lp_n   = lp_b;
    cp_n   = cp_b;
    ff_n   = ff_b;
    if (accept) begin
      if (din != 8'hFF) ff_n = 1'b0;
      if (!cnt_b[8]) begin
        for (int k = 0; k < 8; k++) begin
          if (cnt_b[k]) lp_n[2*k+1] = lp_b[2*k+1] ^ par;
          else          lp_n[2*k]   = lp_b[2*k]   ^ par;
        end
        cp_n[5] = cp_b[5] ^ (^(din & 8'hF0));
        cp_n[4] = cp_b[4] ^ (^(din & 8'h0F));
        cp_n[3] = cp_b[3] ^ (^(din & 8'hCC));
        cp_n[2] = cp_b[2] ^ (^(din & 8'h33));
        cp_n[1] = cp_b[1] ^ (^(din & 8'hAA));
        cp_n[0] = cp_b[0] ^ (^(din & 8'h55));
      end
    end
  end

  // A single-bit data error flips exactly one bit of every parity pair.
  always_comb begin
    for (int p = 0; p < 11; p++) pair_diff[p] = syn_q[2*p+1] ^ syn_q[2*p];
    for (int k = 0; k < 8; k++)  syn_addr[k]  = syn_q[2*k+1];
    if (all_ff)                res = 2'd1;
    else if (syn_q == 22'd0)   res = 2'd1;
    else if (&pair_diff)       res = 2'd2;
    else if ($onehot(syn_q))   res = 2'd1;
    else                       res = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      lp                   <= '0;
      cp                   <= '0;
      all_ff               <= 1'b0;
      s0                   <= '0;
      s1                   <= '0;
      s2                   <= '0;
      idx                  <= '0;
      syn_q                <= '0;
      read_data_ECCstate   <= '0;
      date_change_complete <= 1'b0;
      err_addr             <= '0;
      err_bit              <= '0;
      buf_addr             <= '0;
      buf_rd               <= 1'b0;
      buf_we               <= 1'b0;
      buf_wdata            <= '0;
    end else begin
      buf_rd               <= 1'b0;
      buf_we               <= 1'b0;
      date_change_complete <= 1'b0;
      cnt                  <= accept ? cnt_b + 9'd1 : cnt_b;
      lp                   <= lp_n;
      cp                   <= cp_n;
      all_ff               <= ff_n;
      if (accept) begin
        case (cnt_b)
          9'd256:  s0 <= din;
          9'd257:  s1 <= din;
          9'd258:  s2 <= din[5:0];
          default: ;
        endcase
      end
      if (sector_start) begin
        state              <= ACCUM;
        idx                <= sector_idx;
        read_data_ECCstate <= 2'd0;
      end else begin
        case (state)
          ACCUM:  if (accept && cnt_b == 9'd258) state <= EVAL;
          EVAL: begin
            syn_q <= {cp, lp} ^ {s2, s1, s0};
            state <= RESULT;
          end
          RESULT: begin
            // First RESULT cycle publishes the classification of the registered syndrome.
            if (read_data_ECCstate == 2'd0) begin
              read_data_ECCstate <= res;
              if (res == 2'd2) begin
                err_addr <= {idx, syn_addr};
                err_bit  <= {syn_q[21], syn_q[19], syn_q[17]};
              end
            end else if (correct_start && read_data_ECCstate == 2'd2) begin
              state    <= CORR_RD;
              buf_rd   <= 1'b1;
              buf_addr <= err_addr;
            end
          end
          CORR_RD: state <= CORR_WAIT;
          CORR_WAIT: begin
            buf_we               <= 1'b1;
            buf_wdata            <= buf_rdata ^ (8'h01 << err_bit);
            date_change_complete <= 1'b1;
            state                <= CORR_WR;
          end
          CORR_WR: begin
            read_data_ECCstate <= 2'd0;
            state              <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
